// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared types and helpers for the dual-port RISC-V memory.
//               Provides the access-size encoding, the byte-lane write mask
//               and the alignment check used by the data port.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  // Byte lanes touched by a store of the given size at the given byte offset.
  // Misaligned/illegal combinations are rejected elsewhere before the mask is
  // ever used, so the half case only looks at the upper offset bit.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      MEM_BYTE: mask = 4'b0001 << addr_lo;
      MEM_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: mask = 4'b1111;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // True when the access is not naturally aligned or the size code is illegal.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (size)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = addr_lo[0];
      MEM_WORD: bad = (addr_lo != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_load_align.sv
`default_nettype none
// ============================================================================
// Module      : riscv_load_align
// Description : Combinational load formatter. Selects the addressed byte or
//               half from a raw 32-bit word and sign- or zero-extends it.
// Ports       : raw_word    in  32  word read from the array
//               addr_lo     in   2  byte offset of the access
//               size        in   2  access size (byte/half/word)
//               is_unsigned in   1  1 = zero-extend, 0 = sign-extend
//               result      out 32  right-justified, extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Equivalent to shifting the word down by addr_lo*8 and keeping the low part.
    byte_sel = raw_word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
    case (size)
      MEM_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      MEM_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      MEM_WORD: result = raw_word;
      default:  result = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_memory_dual_port.sv
`default_nettype none
// ============================================================================
// Module      : riscv_memory_dual_port
// Description : Shared word array with a read-only instruction port (I) and a
//               byte/half/word load-store data port (D). Read latency 1 or 2,
//               one request per port per cycle, misaligned/out-of-range data
//               accesses reported on d_error.
// Ports       : clk, rst (async, active-low)
//               I: i_read_en, i_address -> i_read_data, i_read_valid
//               D: d_read_en, d_write_en, d_address, d_size, d_unsigned,
//                  d_write_data -> d_read_data, d_read_valid, d_error
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_memory_dual_port
  import riscv_mem_pkg::*;
#(
  parameter string       MEMORY_FILENAME      = "",
  parameter int          MEMORY_WORDS         = 1024,
  parameter logic [31:0] MEMORY_OFFSET        = 32'h0,
  parameter int          READ_LATENCY         = 1,
  parameter int          WRITE_FIRST          = 0,
  parameter logic [31:0] DEFAULT_MEMORY_VALUE = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read_en,
  input  logic [31:0] i_address,
  output logic [31:0] i_read_data,
  output logic        i_read_valid,
  input  logic        d_read_en,
  input  logic        d_write_en,
  input  logic [31:0] d_address,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_write_data,
  output logic [31:0] d_read_data,
  output logic        d_read_valid,
  output logic        d_error
);

  localparam int IDX_W  = $clog2(MEMORY_WORDS);
  localparam int HI_LSB = IDX_W + 2;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [31:0] mem_array [MEMORY_WORDS] = '{default: DEFAULT_MEMORY_VALUE};

  // Instruction fetches are always word-sized.
  logic unused_i_lo;
  assign unused_i_lo = ^i_address[1:0];

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] i_idx, d_idx;
  logic             i_in_range, d_in_range;
  logic             d_err_now, wr_fire, i_collide;
  logic [3:0]       wr_mask;
  logic [31:0]      wr_data_rep, wr_merged, i_word_now, d_word_now;

  always_comb begin
    i_idx      = i_address[HI_LSB-1:2];
    d_idx      = d_address[HI_LSB-1:2];
    i_in_range = (i_address[31:HI_LSB] == MEMORY_OFFSET[31:HI_LSB]);
    d_in_range = (d_address[31:HI_LSB] == MEMORY_OFFSET[31:HI_LSB]);

    d_err_now = (d_read_en || d_write_en) &&
                (!d_in_range || misaligned(d_size, d_address[1:0]) ||
                 (d_read_en && d_write_en));

    // No store may land while reset is asserted, even on a clock edge.
    wr_fire = rst && d_write_en && !d_err_now;
    wr_mask = lane_mask(d_size, d_address[1:0]);

    // Replicating the store data lets every lane take its byte from the same
    // position regardless of the address offset.
    case (d_size)
      MEM_BYTE: wr_data_rep = {4{d_write_data[7:0]}};
      MEM_HALF: wr_data_rep = {2{d_write_data[15:0]}};
      default:  wr_data_rep = d_write_data;
    endcase

    for (int b = 0; b < 4; b++) begin
      wr_merged[8*b +: 8] = wr_mask[b] ? wr_data_rep[8*b +: 8]
                                       : mem_array[d_idx][8*b +: 8];
    end

    i_collide = i_read_en && i_in_range && wr_fire && (i_idx == d_idx);

    if (!i_in_range)
      i_word_now = 32'h0;
    else if (i_collide && (WRITE_FIRST != 0))
      i_word_now = wr_merged;
    else
      i_word_now = mem_array[i_idx];

    d_word_now = d_err_now ? 32'h0 : mem_array[d_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem_array[d_idx][8*b +: 8] <= wr_data_rep[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: raw word plus the attributes needed to format it
  // --------------------------------------------------------------------------
  logic        i_valid_d, i_valid_q;
  logic [31:0] i_word_d,  i_word_q;
  logic        d_valid_d, d_valid_q;
  logic        d_err_d,   d_err_q;
  logic [31:0] d_word_d,  d_word_q;
  logic [1:0]  d_lo_d,    d_lo_q;
  logic [1:0]  d_size_d,  d_size_q;
  logic        d_uns_d,   d_uns_q;

  always_comb begin
    i_valid_d = i_read_en;
    i_word_d  = i_word_q;
    if (i_read_en) i_word_d = i_word_now;

    // Every load gets exactly one response (flagged by d_error when bad);
    // stores only respond when they fail.
    d_valid_d = d_read_en;
    d_err_d   = d_err_now;
    d_word_d  = d_word_q;
    d_lo_d    = d_lo_q;
    d_size_d  = d_size_q;
    d_uns_d   = d_uns_q;
    if (d_read_en || d_err_now) begin
      d_word_d = d_word_now;   // zero on error, so the formatted result is zero
      d_lo_d   = d_address[1:0];
      d_size_d = d_size;
      d_uns_d  = d_unsigned;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_valid_q <= 1'b0;
      i_word_q  <= 32'h0;
      d_valid_q <= 1'b0;
      d_err_q   <= 1'b0;
      d_word_q  <= 32'h0;
      d_lo_q    <= 2'b00;
      d_size_q  <= 2'b00;
      d_uns_q   <= 1'b0;
    end else begin
      i_valid_q <= i_valid_d;
      i_word_q  <= i_word_d;
      d_valid_q <= d_valid_d;
      d_err_q   <= d_err_d;
      d_word_q  <= d_word_d;
      d_lo_q    <= d_lo_d;
      d_size_q  <= d_size_d;
      d_uns_q   <= d_uns_d;
    end
  end

  logic [31:0] d_aligned;

  riscv_load_align u_load_align (
    .raw_word    (d_word_q),
    .addr_lo     (d_lo_q),
    .size        (d_size_q),
    .is_unsigned (d_uns_q),
    .result      (d_aligned)
  );

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  if (READ_LATENCY == 1) begin : g_lat1
    assign i_read_data  = i_word_q;
    assign i_read_valid = i_valid_q;
    assign d_read_data  = d_aligned;
    assign d_read_valid = d_valid_q;
    assign d_error      = d_err_q;
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic        i_valid2_d, i_valid2_q;
    logic [31:0] i_data2_d,  i_data2_q;
    logic        d_valid2_d, d_valid2_q;
    logic        d_err2_d,   d_err2_q;
    logic [31:0] d_data2_d,  d_data2_q;

    always_comb begin
      i_valid2_d = i_valid_q;
      i_data2_d  = i_valid_q ? i_word_q : i_data2_q;
      d_valid2_d = d_valid_q;
      d_err2_d   = d_err_q;
      d_data2_d  = (d_valid_q || d_err_q) ? d_aligned : d_data2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        i_valid2_q <= 1'b0;
        i_data2_q  <= 32'h0;
        d_valid2_q <= 1'b0;
        d_err2_q   <= 1'b0;
        d_data2_q  <= 32'h0;
      end else begin
        i_valid2_q <= i_valid2_d;
        i_data2_q  <= i_data2_d;
        d_valid2_q <= d_valid2_d;
        d_err2_q   <= d_err2_d;
        d_data2_q  <= d_data2_d;
      end
    end

    assign i_read_data  = i_data2_q;
    assign i_read_valid = i_valid2_q;
    assign d_read_data  = d_data2_q;
    assign d_read_valid = d_valid2_q;
    assign d_error      = d_err2_q;
  end else begin : g_bad_latency
    $error("riscv_memory_dual_port: READ_LATENCY must be 1 or 2");
    assign i_read_data  = 32'h0;
    assign i_read_valid = 1'b0;
    assign d_read_data  = 32'h0;
    assign d_read_valid = 1'b0;
    assign d_error      = 1'b0;
  end

endmodule
`default_nettype wire
